fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 100 ++++++++++
 tb/tb_fifo_stream_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pulls words from a first-word-fall-through-less FIFO (read data arrives one
// cycle after the pop request) and presents them as a valid/ready stream.
// A two-entry skid buffer plus an in-flight flag allows one word per cycle
// without overflow and without dropping words under backpressure.
// Optional feature: define FIFO_RD_CNT_EN to add the 16-bit pop_cnt output
// counting accepted stream beats.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]      pop_cnt
`endif
);

  // Buffer occupancy, slot pointers and the in-flight flag for a pending read
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             inflight;
  logic             head;
  logic             head_next;
  logic             tail;
  logic             tail_next;
  logic [WIDTH-1:0] slot_q    [2];
  logic [WIDTH-1:0] slot_next [2];

  // Handshake events and the projected fill level once this cycle's pop leaves
  logic             pop;
  logic             capture;
  logic [2:0]       level_after_pop;

  // A beat leaves when the consumer takes it; a word lands when a read was issued last cycle
  always_comb begin
    pop     = m_valid && m_ready;
    capture = inflight;
  end

  // Request a pop only while there is guaranteed room for the word two cycles out;
  // the current-cycle pop frees a slot, hence the intentional m_ready-to-rd_en path
  always_comb begin
    level_after_pop = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en      = rst_n && !fifo_empty && (level_after_pop < 3'd2);
  end

  // Next buffer contents: write the arriving word at the tail, retire the head on pop
  always_comb begin
    occ_next     = level_after_pop[1:0];
    head_next    = head ^ pop;
    tail_next    = tail ^ capture;
    slot_next[0] = slot_q[0];
    slot_next[1] = slot_q[1];
    if (capture) begin
      slot_next[tail] = fifo_dout;
    end
  end

  // State register; outputs are registered from the next-state view of the buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      occ       <= occ_next;
      inflight  <= fifo_rd_en;
      head      <= head_next;
      tail      <= tail_next;
      slot_q[0] <= slot_next[0];
      slot_q[1] <= slot_next[1];
      m_valid   <= (occ_next != 2'd0);
      m_data    <= slot_next[head_next];
    end
  end

`ifdef FIFO_RD_CNT_EN
  // Count accepted beats, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_cnt <= 16'd0;
    end else if (pop) begin
      pop_cnt <= pop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Directed table of per-cycle vectors plus hand-written sequences for
// streaming, single-word, random-stress and (with FIFO_RD_CNT_EN) counter cases.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] pop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Upstream FIFO model: read data appears the cycle after a pop request
  logic [7:0]  mem [256];
  logic [31:0] wp = 32'd0;
  logic [31:0] rp = 32'd0;

  assign fifo_empty = (wp == rp);

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_CNT_EN
    ,
    .pop_cnt    (pop_cnt)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // FIFO model read side; flushed by the shared reset
  always @(posedge clk) begin
    if (!rst_n) begin
      rp <= wp;
    end else if (fifo_rd_en) begin
      fifo_dout <= mem[rp[7:0]];
      rp        <= rp + 32'd1;
    end
  end

  typedef struct {
    logic       rst;
    logic       push;
    logic [7:0] din;
    logic       rdy;
    logic       e_rd;
    logic       e_mv;
    logic       chk_md;
    logic [7:0] e_md;
  } vec_t;

  vec_t vecs [24];
  logic [7:0] exp_q [$];

  task automatic push_word(input logic [7:0] d);
    mem[wp[7:0]] = d;
    wp = wp + 32'd1;
  endtask

  task automatic apply_stimulus(input logic rst, input logic push, input logic [7:0] d,
                                input logic rdy);
    @(negedge clk);
    rst_n = rst;
    if (push) push_word(d);
    m_ready = rdy;
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int first_rd;
    int rd_pulses;
    int beats;
    int empty_pops;
    int overflow;
    int level;
    int acc;
    logic [7:0] beat_data;
    logic [7:0] d;
    logic       do_push;
    logic       rdy;
    logic [7:0] exp_word;

    // rst, push, din, rdy, exp rd_en, exp m_valid, check m_data, exp m_data
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
    vecs[5]  = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04};
    vecs[8]  = '{1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
    vecs[11] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3};
    vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[19] = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[20] = '{1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[21] = '{1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB0};
    vecs[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    rst_n   = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].rdy);
      check_output($sformatf("vec%0d rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].e_rd));
      check_output($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      if (vecs[i].chk_md)
        check_output($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].e_md));
    end

    $display("[TB] streaming 0x01..0x08");
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    m_ready = 1'b1;
    #1;
    first_rd = fifo_rd_en ? 0 : -1;
    check_output("stream first rd_en", 32'(fifo_rd_en), 32'd1);
    check_output("stream cycle0 m_valid", 32'(m_valid), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
      if (c == 1) check_output("stream cycle1 m_valid", 32'(m_valid), 32'd0);
      if (c >= 2 && c <= 9) begin
        check_output($sformatf("stream beat%0d m_valid", c - 2), 32'(m_valid), 32'd1);
        check_output($sformatf("stream beat%0d m_data", c - 2), 32'(m_data), 32'(c - 1));
      end
      if (c == 8) check_output("stream rd_en after drain", 32'(fifo_rd_en), 32'd0);
      if (c == 10) check_output("stream m_valid after last", 32'(m_valid), 32'd0);
    end
    check_output("stream first rd cycle", 32'(first_rd), 32'd0);

    $display("[TB] single word empty boundary");
    rd_pulses  = 0;
    beats      = 0;
    empty_pops = 0;
    beat_data  = 8'h00;
    @(negedge clk);
    push_word(8'h5A);
    m_ready = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
      if (fifo_rd_en) rd_pulses++;
      if (fifo_rd_en && fifo_empty) empty_pops++;
      if (m_valid && m_ready) begin
        beats++;
        beat_data = m_data;
      end
    end
    check_output("single rd_en pulses", 32'(rd_pulses), 32'd1);
    check_output("single beats", 32'(beats), 32'd1);
    check_output("single beat data", 32'(beat_data), 32'h5A);
    check_output("single rd_en while empty", 32'(empty_pops), 32'd0);

    $display("[TB] random stress");
    exp_q.delete();
    level      = 0;
    overflow   = 0;
    empty_pops = 0;
    for (int c = 0; c < 1000; c++) begin
      d       = 8'($urandom);
      do_push = ($urandom_range(0, 1) == 1) && ((wp - rp) < 32'd100);
      rdy     = ($urandom_range(0, 1) == 1);
      apply_stimulus(1'b1, do_push, d, rdy);
      if (do_push) exp_q.push_back(d);
      if (fifo_rd_en && fifo_empty) empty_pops++;
      if (m_valid && m_ready) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check_output($sformatf("stress beat cycle%0d", c), 32'(m_data), 32'(exp_word));
      end
      level = level + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (level > 2) overflow++;
    end
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
      if (fifo_rd_en && fifo_empty) empty_pops++;
      if (m_valid && m_ready) begin
        exp_word = exp_q.pop_front();
        check_output($sformatf("drain beat%0d", c), 32'(m_data), 32'(exp_word));
      end
    end
    check_output("stress words left", 32'(exp_q.size()), 32'd0);
    check_output("stress rd_en while empty", 32'(empty_pops), 32'd0);
    check_output("stress overflow", 32'(overflow), 32'd0);

`ifdef FIFO_RD_CNT_EN
    $display("[TB] pop counter wrap");
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
    check_output("cnt after reset", 32'(pop_cnt), 32'd0);
    acc = 0;
    for (int c = 0; c < 70000 && acc < 65537; c++) begin
      apply_stimulus(1'b1, 1'b1, 8'(c), 1'b1);
      if (m_valid && m_ready) acc++;
    end
    check_output("cnt beats reached", 32'(acc), 32'd65537);
    @(negedge clk);
    #1;
    check_output("cnt wrapped", 32'(pop_cnt), 32'd1);
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b1);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check_output("cnt mid-stream reset", 32'(pop_cnt), 32'd0);
`else
    acc = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
